// File: rtl/keccak_round_ctrl_if.sv
// Handshake/control bundle between the Keccak round controller and its
// sponge wrapper / round datapath.
interface keccak_round_ctrl_if;
  logic       start_i;
  logic       abort_i;
  logic       ready_o;
  logic       load_o;
  logic       round_en_o;
  logic [4:0] round_number_o;
  logic       last_round_o;
  logic       busy_o;
  logic       valid_o;
  logic       ready_i;

  // controller side
  modport master (
    input  start_i, abort_i, ready_i,
    output ready_o, load_o, round_en_o, round_number_o, last_round_o, busy_o, valid_o
  );

  // wrapper/datapath side
  modport slave (
    output start_i, abort_i, ready_i,
    input  ready_o, load_o, round_en_o, round_number_o, last_round_o, busy_o, valid_o
  );
endinterface

// File: rtl/keccak_round_ctrl.sv
// Sequencer for the Keccak-f[1600] datapath: IDLE -> LOAD -> RUN (round index
// steps by ROUNDS_PER_CYCLE) -> DONE (result held until the consumer takes it).
module keccak_round_ctrl #(
  parameter int NUM_ROUNDS       = 24,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  keccak_round_ctrl_if.master  bus
);

  if ((NUM_ROUNDS < 1) || (NUM_ROUNDS > 24) || (ROUNDS_PER_CYCLE < 1) ||
      (NUM_ROUNDS % ROUNDS_PER_CYCLE != 0)) begin : g_param_check
    $error("keccak_round_ctrl: illegal NUM_ROUNDS/ROUNDS_PER_CYCLE combination");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [4:0] LAST_CNT = 5'(NUM_ROUNDS - ROUNDS_PER_CYCLE);
  localparam logic [4:0] STEP     = 5'(ROUNDS_PER_CYCLE);

  logic [1:0] state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic       at_last;

  assign at_last = (cnt == LAST_CNT);

  // abort outranks every other transition, including start and completion
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (bus.abort_i) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: if (bus.start_i) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
        LOAD: state_nxt = RUN;
        RUN: if (at_last) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + STEP;
        end
        DONE: if (bus.ready_i) state_nxt = IDLE;
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Moore decode: outputs depend on registers only, so reset reaches them without a clock
  assign bus.ready_o        = (state == IDLE);
  assign bus.load_o         = (state == LOAD);
  assign bus.round_en_o     = (state == RUN);
  assign bus.round_number_o = (state == RUN) ? cnt : 5'd0;
  assign bus.last_round_o   = (state == RUN) && at_last;
  assign bus.busy_o         = (state == LOAD) || (state == RUN);
  assign bus.valid_o        = (state == DONE);

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Directed bench: default controller (24x1) plus a 4-rounds-per-cycle instance.
module tb_keccak_round_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  keccak_round_ctrl_if a ();
  keccak_round_ctrl_if b ();

  keccak_round_ctrl dut_a (.clk(clk), .rst(rst), .bus(a));
  keccak_round_ctrl #(.NUM_ROUNDS(24), .ROUNDS_PER_CYCLE(4)) dut_b (.clk(clk), .rst(rst), .bus(b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, ".ready"}, 32'(a.ready_o), 1);
    chk({tag, ".load"}, 32'(a.load_o), 0);
    chk({tag, ".round_en"}, 32'(a.round_en_o), 0);
    chk({tag, ".round_num"}, 32'(a.round_number_o), 0);
    chk({tag, ".last"}, 32'(a.last_round_o), 0);
    chk({tag, ".busy"}, 32'(a.busy_o), 0);
    chk({tag, ".valid"}, 32'(a.valid_o), 0);
  endtask

  // start pulse from IDLE, then check LOAD, 24 rounds and DONE
  task automatic run_perm_a(input string tag);
    a.start_i = 1'b1;
    tick();
    a.start_i = 1'b0;
    chk({tag, ".load"}, 32'(a.load_o), 1);
    chk({tag, ".load_busy"}, 32'(a.busy_o), 1);
    chk({tag, ".load_ready"}, 32'(a.ready_o), 0);
    for (int r = 0; r < 24; r++) begin
      tick();
      chk({tag, ".rnd_en"}, 32'(a.round_en_o), 1);
      chk({tag, ".rnd_num"}, 32'(a.round_number_o), 32'(r));
      chk({tag, ".rnd_last"}, 32'(a.last_round_o), 32'(r == 23));
      chk({tag, ".rnd_valid"}, 32'(a.valid_o), 0);
    end
    tick();
    chk({tag, ".valid"}, 32'(a.valid_o), 1);
    chk({tag, ".done_en"}, 32'(a.round_en_o), 0);
    chk({tag, ".done_num"}, 32'(a.round_number_o), 0);
    chk({tag, ".done_busy"}, 32'(a.busy_o), 0);
  endtask

  initial begin
    a.start_i = 1'b0; a.abort_i = 1'b0; a.ready_i = 1'b0;
    b.start_i = 1'b0; b.abort_i = 1'b0; b.ready_i = 1'b0;

    // reset state
    #2;
    chk_idle_a("reset");
    chk("reset.b_ready", 32'(b.ready_o), 1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_idle_a("post_reset");

    // test 1: single permutation, default config
    run_perm_a("t1");

    // test 3: consumer stalls 10 cycles; extra start ignored
    a.start_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3.valid_hold", 32'(a.valid_o), 1);
      chk("t3.ready_low", 32'(a.ready_o), 0);
      chk("t3.no_load", 32'(a.load_o), 0);
    end
    a.start_i = 1'b0;
    a.ready_i = 1'b1;
    tick();
    a.ready_i = 1'b0;
    chk_idle_a("t3.released");

    // ready_i outside DONE and abort beating start in IDLE
    a.ready_i = 1'b1; a.abort_i = 1'b1; a.start_i = 1'b1;
    tick();
    a.ready_i = 1'b0; a.abort_i = 1'b0; a.start_i = 1'b0;
    chk_idle_a("abort_vs_start");

    // test 2: 4 rounds per cycle
    b.start_i = 1'b1;
    tick();
    b.start_i = 1'b0;
    chk("t2.load", 32'(b.load_o), 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t2.rnd_en", 32'(b.round_en_o), 1);
      chk("t2.rnd_num", 32'(b.round_number_o), 32'(4 * k));
      chk("t2.rnd_last", 32'(b.last_round_o), 32'(k == 5));
    end
    tick();
    chk("t2.valid", 32'(b.valid_o), 1);
    chk("t2.done_en", 32'(b.round_en_o), 0);
    b.ready_i = 1'b1;
    tick();
    b.ready_i = 1'b0;
    chk("t2.ready_back", 32'(b.ready_o), 1);
    chk("t2.valid_gone", 32'(b.valid_o), 0);

    // test 4: abort at round 11
    a.start_i = 1'b1;
    tick();
    a.start_i = 1'b0;
    for (int r = 0; r < 12; r++) tick();
    chk("t4.at_round", 32'(a.round_number_o), 11);
    a.abort_i = 1'b1;
    tick();
    a.abort_i = 1'b0;
    chk_idle_a("t4.aborted");
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4.no_valid", 32'(a.valid_o), 0);
    end
    run_perm_a("t4.rerun");
    a.ready_i = 1'b1;
    tick();
    a.ready_i = 1'b0;
    chk_idle_a("t4.idle");

    // test 5: async reset at round 7, mid-cycle
    a.start_i = 1'b1;
    tick();
    a.start_i = 1'b0;
    for (int r = 0; r < 8; r++) tick();
    chk("t5.at_round", 32'(a.round_number_o), 7);
    #2;
    rst = 1'b1;
    #1;
    chk_idle_a("t5.async_rst");
    #1;
    rst = 1'b0;
    tick();
    chk_idle_a("t5.after_rst");
    run_perm_a("t5.rerun");
    a.ready_i = 1'b1;
    tick();
    chk_idle_a("t5.idle");

    // test 6: back-to-back, start and ready_i held high; 27-cycle period
    a.start_i = 1'b1;
    for (int p = 0; p < 3; p++) begin
      tick();
      chk("t6.load", 32'(a.load_o), 1);
      for (int r = 0; r < 24; r++) begin
        tick();
        chk("t6.rnd_num", 32'(a.round_number_o), 32'(r));
        chk("t6.rnd_last", 32'(a.last_round_o), 32'(r == 23));
      end
      tick();
      chk("t6.valid", 32'(a.valid_o), 1);
      chk("t6.done_ready", 32'(a.ready_o), 0);
      tick();
      chk("t6.idle_ready", 32'(a.ready_o), 1);
      chk("t6.idle_load", 32'(a.load_o), 0);
    end
    a.start_i = 1'b0;
    a.ready_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
